// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/gnt + rvalid/rdata, redirect,
// decode stall and the head-of-queue instruction handed to decode.
// With IFU_PERF_CNT_EN defined, the two performance counters are carried too.
interface ifu_prefetch_if #(
    parameter int XLEN = 32
);
    logic            o_IM_req;
    logic [XLEN-1:0] o_IM_addr;
    logic            i_IM_gnt;
    logic            i_IM_rvalid;
    logic [XLEN-1:0] i_IM_rdata;
    logic            i_flush;
    logic [XLEN-1:0] i_branch_addr;
    logic            i_ex_stall;
    logic            o_inst_valid;
    logic [XLEN-1:0] o_inst;
    logic [XLEN-1:0] o_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]     o_fetch_cnt;
    logic [31:0]     o_drop_cnt;
`endif

    // Fetch unit side
    modport master (
        input  i_IM_gnt, i_IM_rvalid, i_IM_rdata, i_flush, i_branch_addr, i_ex_stall,
        output o_IM_req, o_IM_addr, o_inst_valid, o_inst, o_pc
`ifdef IFU_PERF_CNT_EN
        , output o_fetch_cnt, o_drop_cnt
`endif
    );

    // Memory / pipeline side
    modport slave (
        output i_IM_gnt, i_IM_rvalid, i_IM_rdata, i_flush, i_branch_addr, i_ex_stall,
        input  o_IM_req, o_IM_addr, o_inst_valid, o_inst, o_pc
`ifdef IFU_PERF_CNT_EN
        , input o_fetch_cnt, o_drop_cnt
`endif
    );
endinterface

// File: rtl/ifu_prefetch.sv
// In-order instruction prefetch queue between instruction memory and decode.
// A slot is reserved (with its PC) when a request is granted and filled when the
// in-order response returns; decode pops the head once it is filled.
// A redirect clears every slot and counts the still-outstanding responses into
// 'drop' so they are discarded when they arrive.
// Optional feature macro: IFU_PERF_CNT_EN (fetch / discard counters).
module ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    ifu_prefetch_if.master bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  slot_pc   [DEPTH];
    logic [XLEN-1:0]  slot_inst [DEPTH];
    logic [DEPTH-1:0] slot_filled;
    logic [AW-1:0]    head_q;   // oldest reserved slot (decode side)
    logic [AW-1:0]    tail_q;   // next slot to reserve on issue
    logic [AW-1:0]    fill_q;   // oldest reserved-but-unfilled slot
    logic [CW-1:0]    used_q;
    logic [CW-1:0]    outst_q;
    logic [CW-1:0]    drop_q;

    logic req;
    logic issue;
    logic pop;
    logic resp_keep;
    logic head_valid;

    // Handshake decode for this cycle
    // NOTE: every always_comb output gets a value before any if, so no latch can form.
    always_comb begin
        head_valid = slot_filled[head_q];
        req        = !rst && !bus.i_flush && (used_q < DEPTH_C);
        issue      = req && bus.i_IM_gnt;
        pop        = head_valid && !bus.i_ex_stall && !bus.i_flush;
        resp_keep  = bus.i_IM_rvalid && (drop_q == '0) && !bus.i_flush;
    end

    // Pointers, counters, fill flags and fetch PC; redirect has top priority
    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            used_q      <= '0;
            outst_q     <= '0;
            drop_q      <= '0;
            slot_filled <= '0;
        end else if (bus.i_flush) begin
            pc_q        <= bus.i_branch_addr & ~XLEN'(3);
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            used_q      <= '0;
            slot_filled <= '0;
            // No issue during a redirect, so only a same-cycle response retires
            outst_q     <= outst_q - CW'(bus.i_IM_rvalid);
            drop_q      <= outst_q - CW'(bus.i_IM_rvalid);
        end else begin
            if (issue) begin
                pc_q   <= pc_q + XLEN'(4);
                tail_q <= tail_q + AW'(1);
            end
            if (resp_keep) begin
                fill_q              <= fill_q + AW'(1);
                slot_filled[fill_q] <= 1'b1;
            end
            if (pop) begin
                head_q              <= head_q + AW'(1);
                slot_filled[head_q] <= 1'b0;
            end
            used_q  <= used_q + CW'(issue) - CW'(pop);
            outst_q <= outst_q + CW'(issue) - CW'(bus.i_IM_rvalid);
            if (bus.i_IM_rvalid && (drop_q != '0))
                drop_q <= drop_q - CW'(1);
        end
    end

    // Slot payload storage
    // NOTE: payload RAM is not reset; slot_filled guards every read of it.
    always_ff @(posedge clk) begin
        if (issue)
            slot_pc[tail_q] <= pc_q;
        if (resp_keep)
            slot_inst[fill_q] <= bus.i_IM_rdata;
    end

    assign bus.o_IM_req     = req;
    assign bus.o_IM_addr    = pc_q;
    assign bus.o_inst_valid = head_valid;
    assign bus.o_inst       = head_valid ? slot_inst[head_q] : '0;
    assign bus.o_pc         = head_valid ? slot_pc[head_q]   : '0;

`ifdef IFU_PERF_CNT_EN
    logic [CW-1:0] flushed_filled;
    logic [CW-1:0] drop_inc;
    logic [32:0]   fetch_sum;
    logic [32:0]   drop_sum;
    logic [31:0]   fetch_cnt_q;
    logic [31:0]   drop_cnt_q;

    // Discards this cycle: dropped response plus filled slots lost to a redirect
    always_comb begin
        flushed_filled = '0;
        for (int i = 0; i < DEPTH; i++)
            flushed_filled = flushed_filled + CW'(slot_filled[i]);
        drop_inc  = (bus.i_flush ? flushed_filled : '0)
                  + CW'(bus.i_IM_rvalid && ((drop_q != '0) || bus.i_flush));
        fetch_sum = {1'b0, fetch_cnt_q} + 33'(issue);
        drop_sum  = {1'b0, drop_cnt_q} + 33'(drop_inc);
    end

    // Saturating performance counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_sum[32] ? '1 : fetch_sum[31:0];
            drop_cnt_q  <= drop_sum[32]  ? '1 : drop_sum[31:0];
        end
    end

    assign bus.o_fetch_cnt = fetch_cnt_q;
    assign bus.o_drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: in-order memory responder with 1-cycle
// latency, a scoreboard of expected {pc, inst} pushed on issue and popped when
// decode consumes the head, a vector table for fill/stall timing and
// hand-written redirect, wrap and reset sequences.
module tb_ifu_prefetch;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_prefetch_if #(.XLEN(XLEN)) bus ();

    ifu_prefetch #(.XLEN(XLEN), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          cyc;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic        gnt;
        logic        resp;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t       pending[$];
    exp_t        sb[$];
    vec_t        vec[21];

    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;
    int          pops_n = 0;
    int          epoch  = 0;
    logic [31:0] model_pc = 32'h0;
    logic        chk_first = 1'b1;
    logic [31:0] first_target = 32'h0;

    logic        gnt_c = 1'b0;
    logic        resp_c = 1'b0;
    logic        stall_c = 1'b0;
    logic        flush_c = 1'b0;
    logic [31:0] baddr_c = 32'h0;

`ifdef IFU_PERF_CNT_EN
    int          exp_filled = 0;
    logic [31:0] fetch_model = 0;
    logic [31:0] drop_model = 0;
    logic [31:0] fetch_snap = 0;
    logic [31:0] drop_snap = 0;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic g, input logic r, input logic s, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.resp = r; v.stall = s;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic check_perf();
`ifdef IFU_PERF_CNT_EN
        check("fetch_cnt", bus.o_fetch_cnt, fetch_snap);
        check("drop_cnt", bus.o_drop_cnt, drop_snap);
`endif
    endtask

    // One bus cycle: drive inputs at negedge, settle, update the reference model.
    // Outputs stay valid for the caller to inspect until the next posedge.
    task automatic cycle();
        logic  issue_s;
        logic  pop_s;
        exp_t  e;
        pend_t p;
        @(negedge clk);
        bus.i_IM_gnt      = gnt_c;
        bus.i_ex_stall    = stall_c;
        bus.i_flush       = flush_c;
        bus.i_branch_addr = baddr_c;
        if (resp_c && (pending.size() > 0) && (pending[0].cyc < cyc_n)) begin
            bus.i_IM_rvalid = 1'b1;
            bus.i_IM_rdata  = mem_word(pending[0].addr);
        end else begin
            bus.i_IM_rvalid = 1'b0;
            bus.i_IM_rdata  = 32'hDEAD_BEEF;
        end
        #2;
`ifdef IFU_PERF_CNT_EN
        fetch_snap = fetch_model;
        drop_snap  = drop_model;
`endif
        issue_s = bus.o_IM_req && gnt_c;
        pop_s   = bus.o_inst_valid && !stall_c && !flush_c;

        if (pop_s) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pc 0x%08h, expected no valid head (cycle %0d)",
                         bus.o_pc, cyc_n);
            end else begin
                e = sb.pop_front();
                check("head_pc", bus.o_pc, e.pc);
                check("head_inst", bus.o_inst, e.inst);
                if (chk_first) begin
                    check("first_pc_after_redirect", bus.o_pc, first_target);
                    chk_first = 1'b0;
                end
`ifdef IFU_PERF_CNT_EN
                exp_filled--;
`endif
            end
            pops_n++;
        end

        if (bus.i_IM_rvalid) begin
            p = pending.pop_front();
`ifdef IFU_PERF_CNT_EN
            if (flush_c || (p.ep != epoch))
                drop_model++;
            else
                exp_filled++;
`endif
        end

        if (flush_c) begin
`ifdef IFU_PERF_CNT_EN
            drop_model = drop_model + 32'(exp_filled);
            exp_filled = 0;
`endif
            sb.delete();
            epoch++;
            model_pc     = baddr_c & ~32'h3;
            chk_first    = 1'b1;
            first_target = model_pc;
        end

        if (issue_s) begin
            check("issue_addr", bus.o_IM_addr, model_pc);
            pending.push_back('{addr: model_pc, ep: epoch, cyc: cyc_n});
            sb.push_back('{pc: model_pc, inst: mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
`ifdef IFU_PERF_CNT_EN
            fetch_model++;
`endif
        end
        cyc_n++;
    endtask

    task automatic idle_inputs();
        bus.i_IM_gnt      = 1'b0;
        bus.i_IM_rvalid   = 1'b0;
        bus.i_IM_rdata    = 32'h0;
        bus.i_flush       = 1'b0;
        bus.i_branch_addr = 32'h0;
        bus.i_ex_stall    = 1'b0;
    endtask

    task automatic set_ctl(input logic g, input logic r, input logic s, input logic f,
                           input logic [31:0] ba);
        gnt_c = g; resp_c = r; stall_c = s; flush_c = f; baddr_c = ba;
    endtask

    initial begin
        int pops_before;

        // Vector table: issue until full with no responses, then fill under stall,
        // hold, and release; rows are consecutive cycles starting at reset release.
        for (int i = 0; i < 4; i++) vec[i] = mk(1, 0, 0, 1, 32'(i * 4), 0, 32'h0);
        vec[4] = mk(1, 0, 0, 0, 32'h10, 0, 32'h0);
        vec[5] = mk(1, 0, 0, 0, 32'h10, 0, 32'h0);
        vec[6] = mk(1, 1, 1, 0, 32'h10, 0, 32'h0);
        for (int i = 7; i < 16; i++) vec[i] = mk(1, 1, 1, 0, 32'h10, 1, 32'h0);
        vec[16] = mk(1, 1, 0, 0, 32'h10, 1, 32'h0);
        vec[17] = mk(1, 1, 0, 1, 32'h10, 1, 32'h4);
        vec[18] = mk(1, 1, 0, 1, 32'h14, 1, 32'h8);
        vec[19] = mk(1, 1, 0, 1, 32'h18, 1, 32'hC);
        vec[20] = mk(1, 1, 0, 1, 32'h1C, 1, 32'h10);

        // Reset state
        idle_inputs();
        repeat (2) @(negedge clk);
        #2;
        check("rst_req", 32'(bus.o_IM_req), 32'h0);
        check("rst_valid", 32'(bus.o_inst_valid), 32'h0);
        check("rst_inst", bus.o_inst, 32'h0);
        check("rst_pc", bus.o_pc, 32'h0);
        check_perf();
        @(negedge clk);
        rst = 1'b0;

        // Table-driven: fill latency, full without responses, stall hold, release order
        for (int i = 0; i < 21; i++) begin
            set_ctl(vec[i].gnt, vec[i].resp, vec[i].stall, 1'b0, 32'h0);
            cycle();
            check("tbl_req", 32'(bus.o_IM_req), 32'(vec[i].exp_req));
            check("tbl_addr", bus.o_IM_addr, vec[i].exp_addr);
            check("tbl_valid", 32'(bus.o_inst_valid), 32'(vec[i].exp_valid));
            if (vec[i].exp_valid) begin
                check("tbl_pc", bus.o_pc, vec[i].exp_pc);
                check("tbl_inst", bus.o_inst, mem_word(vec[i].exp_pc));
            end
        end

        // Steady state: one instruction per cycle
        set_ctl(1, 1, 0, 0, 32'h0);
        pops_before = pops_n;
        repeat (20) cycle();
        check("steady_throughput", 32'(pops_n - pops_before), 32'd20);

        // Redirect to 0x103 (-> 0x100) with exactly three requests in flight
        set_ctl(0, 1, 0, 0, 32'h0);
        repeat (6) cycle();
        set_ctl(1, 0, 0, 0, 32'h0);
        repeat (3) cycle();
        set_ctl(1, 0, 0, 1, 32'h103);
        cycle();
        check("flush_req_low", 32'(bus.o_IM_req), 32'h0);
        set_ctl(1, 1, 0, 0, 32'h0);
        cycle();
        check("redirect_addr", bus.o_IM_addr, 32'h100);
        check("drop_no_valid", 32'(bus.o_inst_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("drop_no_valid", 32'(bus.o_inst_valid), 32'h0);
        end
        repeat (10) cycle();
        check_perf();

        // Redirect while stalled with a response arriving the same cycle
        set_ctl(1, 1, 1, 0, 32'h0);
        repeat (2) cycle();
        set_ctl(1, 1, 1, 1, 32'h200);
        cycle();
        check("stalled_flush_rvalid", 32'(bus.i_IM_rvalid && bus.o_inst_valid), 32'h1);
        set_ctl(1, 1, 1, 0, 32'h0);
        cycle();
        check("stalled_flush_head_gone", 32'(bus.o_inst_valid), 32'h0);
        set_ctl(1, 1, 0, 0, 32'h0);
        repeat (10) cycle();

        // Back-to-back redirects: the second target wins
        set_ctl(1, 1, 0, 1, 32'h300);
        cycle();
        set_ctl(1, 1, 0, 1, 32'h3F0);
        cycle();
        set_ctl(1, 1, 0, 0, 32'h0);
        repeat (10) cycle();
        check_perf();

        // PC wrap at 2^32, with low target bits ignored
        set_ctl(1, 1, 0, 1, 32'hFFFF_FFFA);
        cycle();
        set_ctl(1, 1, 0, 0, 32'h0);
        repeat (10) cycle();

        // Reset mid-operation: everything back to reset values, restart from RESET_PC
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #2;
        check("midrst_req", 32'(bus.o_IM_req), 32'h0);
        check("midrst_valid", 32'(bus.o_inst_valid), 32'h0);
        check("midrst_inst", bus.o_inst, 32'h0);
        check("midrst_pc", bus.o_pc, 32'h0);
        check("midrst_addr", bus.o_IM_addr, 32'h0);
        pending.delete();
        sb.delete();
        epoch++;
        model_pc     = 32'h0;
        chk_first    = 1'b1;
        first_target = 32'h0;
`ifdef IFU_PERF_CNT_EN
        exp_filled  = 0;
        fetch_model = 0;
        drop_model  = 0;
        fetch_snap  = 0;
        drop_snap   = 0;
`endif
        check_perf();
        @(negedge clk);
        rst = 1'b0;
        set_ctl(1, 1, 0, 0, 32'h0);
        pops_before = pops_n;
        repeat (10) cycle();
        check("post_reset_progress", 32'(pops_n - pops_before), 32'd8);
        check_perf();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
